// File: rtl/fsk_pkg.sv
// rtl/fsk_pkg.sv - shared 8-FSK symbol widths, frame states and default timing
package fsk_pkg;

    localparam int SYM_W            = 3;
    localparam int NUM_TONES        = 8;
    localparam int DEF_SPS          = 64;
    localparam int DEF_SYNC_WAIT    = 12;
    localparam int DEF_GUARD_CYCLES = 4;
    localparam int DEF_CNT_W        = 16;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        PREAMBLE = 2'd1,
        SYMBOL   = 2'd2,
        GUARD    = 2'd3
    } fsk_state_t;

endpackage

// File: rtl/fsk_period_timer.sv
// rtl/fsk_period_timer.sv - loadable down-counter with terminal-count flags
module fsk_period_timer #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [CNT_W-1:0] load_value,
    output logic             tc,
    output logic             tc_next
);

    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] count_next;

    // Saturates at zero so an idle scheduler leaves the timer parked.
    always_comb begin
        count_next = count;
        if (load)
            count_next = load_value;
        else if (count != '0)
            count_next = count - CNT_W'(1);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            count <= '0;
        else
            count <= count_next;
    end

    assign tc      = (count == '0);
    assign tc_next = (count_next == '0);

endmodule

// File: rtl/fsk_frame_scheduler.sv
// rtl/fsk_frame_scheduler.sv - sequences preamble, symbol periods and guard gap for the 8-FSK modulator
module fsk_frame_scheduler
    import fsk_pkg::*;
#(
    parameter int               SPS          = DEF_SPS,
    parameter int               SYNC_WAIT    = DEF_SYNC_WAIT,
    parameter int               GUARD_CYCLES = DEF_GUARD_CYCLES,
    parameter logic [SYM_W-1:0] IDLE_SYMBOL  = '0,
    parameter int               CNT_W        = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             frame_req,
    input  logic [7:0]       frame_len,
    output logic             frame_busy,
    output logic             frame_done,
    output logic             frame_err,
    input  logic             sym_valid,
    input  logic [SYM_W-1:0] sym_data,
    output logic             sym_ready,
    output logic             mod_start,
    output logic [SYM_W-1:0] mod_data,
    output logic             underrun,
    output logic [7:0]       sym_count
);

    fsk_state_t       state, next_state;
    logic [7:0]       len_q;
    logic             tc, tc_next;
    logic             timer_load;
    logic [CNT_W-1:0] timer_value;
    logic             last_symbol;
    logic             frame_accept;

    logic             busy_d, start_d, done_d;
    logic [SYM_W-1:0] data_d;
    logic [7:0]       count_d, len_d;

    fsk_period_timer #(
        .CNT_W (CNT_W)
    ) u_timer (
        .clk        (clk),
        .reset      (reset),
        .load       (timer_load),
        .load_value (timer_value),
        .tc         (tc),
        .tc_next    (tc_next)
    );

    // sym_count already includes the symbol now on air, so equality marks the final one.
    assign last_symbol = (sym_count == len_q);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            len_q      <= '0;
            sym_count  <= '0;
            mod_data   <= IDLE_SYMBOL;
            frame_busy <= 1'b0;
            mod_start  <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            state      <= next_state;
            len_q      <= len_d;
            sym_count  <= count_d;
            mod_data   <= data_d;
            frame_busy <= busy_d;
            mod_start  <= start_d;
            frame_done <= done_d;
        end
    end

    always_comb begin
        next_state  = state;
        timer_load  = 1'b0;
        timer_value = '0;
        case (state)
            IDLE: begin
                if (frame_req && (frame_len != 8'd0)) begin
                    next_state  = PREAMBLE;
                    timer_load  = 1'b1;
                    timer_value = CNT_W'(SYNC_WAIT - 1);
                end
            end
            PREAMBLE: begin
                if (tc) begin
                    next_state  = SYMBOL;
                    timer_load  = 1'b1;
                    timer_value = CNT_W'(SPS - 1);
                end
            end
            SYMBOL: begin
                if (tc) begin
                    timer_load = 1'b1;
                    if (last_symbol) begin
                        next_state  = GUARD;
                        timer_value = CNT_W'(GUARD_CYCLES - 1);
                    end else begin
                        timer_value = CNT_W'(SPS - 1);
                    end
                end
            end
            GUARD: begin
                if (tc)
                    next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    // Registered outputs are computed from the upcoming state so they line up with it.
    always_comb begin
        sym_ready    = tc && ((state == PREAMBLE) || ((state == SYMBOL) && !last_symbol));
        underrun     = sym_ready && !sym_valid;
        frame_err    = (state == IDLE) && frame_req && (frame_len == 8'd0);
        frame_accept = (state == IDLE) && (next_state == PREAMBLE);

        busy_d  = (next_state != IDLE);
        start_d = frame_accept;
        done_d  = (next_state == GUARD) && tc_next;
        len_d   = frame_accept ? frame_len : len_q;

        count_d = sym_count;
        if (frame_accept)
            count_d = 8'd0;
        else if (sym_ready)
            count_d = sym_count + 8'd1;

        data_d = mod_data;
        if (sym_ready)
            data_d = sym_valid ? sym_data : IDLE_SYMBOL;
        else if (next_state != SYMBOL)
            data_d = IDLE_SYMBOL;
    end

endmodule

// File: tb/tb_fsk_frame_scheduler.sv
// tb/tb_fsk_frame_scheduler.sv - self-checking bench for fsk_frame_scheduler
module tb_fsk_frame_scheduler;

    localparam int SPS  = 4;
    localparam int SW   = 12;
    localparam int GC   = 4;
    localparam int MAXC = 1100;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       frame_req = 1'b0;
    logic [7:0] frame_len = 8'd0;
    logic       sym_valid = 1'b0;
    logic [2:0] sym_data = 3'd0;
    logic       frame_busy, frame_done, frame_err, sym_ready, mod_start, underrun;
    logic [2:0] mod_data;
    logic [7:0] sym_count;

    fsk_frame_scheduler #(
        .SPS          (SPS),
        .SYNC_WAIT    (SW),
        .GUARD_CYCLES (GC),
        .IDLE_SYMBOL  (3'd0),
        .CNT_W        (16)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .frame_req  (frame_req),
        .frame_len  (frame_len),
        .frame_busy (frame_busy),
        .frame_done (frame_done),
        .frame_err  (frame_err),
        .sym_valid  (sym_valid),
        .sym_data   (sym_data),
        .sym_ready  (sym_ready),
        .mod_start  (mod_start),
        .mod_data   (mod_data),
        .underrun   (underrun),
        .sym_count  (sym_count)
    );

    always #5 clk = ~clk;

    bit         st_req[MAXC], st_valid[MAXC], st_rst[MAXC];
    logic [7:0] st_len[MAXC];
    logic [2:0] st_data[MAXC];

    bit         e_busy[MAXC], e_start[MAXC], e_done[MAXC], e_err[MAXC], e_ready[MAXC], e_under[MAXC];
    int         e_data[MAXC], e_count[MAXC];
    bit         c_busy[MAXC], c_start[MAXC], c_done[MAXC], c_err[MAXC], c_ready[MAXC], c_under[MAXC];
    int         c_data[MAXC], c_count[MAXC];

    int src[$];
    int src_idx;
    int total = 0;
    int bad = 0;
    int cyc = 0;
    bit checking = 1'b0;

    task automatic chk(input string nm, input int c, input int act, input int expv);
        total++;
        if (act != expv) begin
            bad++;
            $display("FAIL %s cycle %0d: got %0d expected %0d", nm, c, act, expv);
        end
    endtask

    task automatic clear_plan();
        for (int c = 0; c < MAXC; c++) begin
            st_req[c] = 0; st_len[c] = 8'd0; st_valid[c] = 1; st_rst[c] = 0;
            st_data[c] = 3'($urandom_range(0, 7));
            e_busy[c] = 0; e_start[c] = 0; e_done[c] = 0; e_err[c] = 0;
            e_ready[c] = 0; e_under[c] = 0; e_data[c] = 0; e_count[c] = 0;
        end
        src.delete();
        src_idx = 0;
    endtask

    // Frame accepted at cycle s: preamble s+1..s+SW, symbol k in the SPS cycles after
    // strobe s+SW+k*SPS, guard afterwards, done on the final guard cycle.
    task automatic plan_frame(input int s, input int len);
        int fin;
        int t;
        int v;
        fin = s + SW + len * SPS + GC;
        e_start[s+1] = 1;
        for (int c = s + 1; c <= fin; c++) e_busy[c] = 1;
        for (int c = s + 1; c <= s + SW; c++) begin e_count[c] = 0; e_data[c] = 0; end
        for (int k = 0; k < len; k++) begin
            t = s + SW + k * SPS;
            e_ready[t] = 1;
            if (!st_valid[t]) begin
                e_under[t] = 1;
                v = 0;
            end else begin
                v = src[src_idx];
                src_idx++;
                st_data[t] = 3'(v);
            end
            for (int c = t + 1; c <= t + SPS; c++) begin e_data[c] = v; e_count[c] = k + 1; end
        end
        for (int c = fin - GC + 1; c <= fin; c++) begin e_data[c] = 0; e_count[c] = len; end
        e_done[fin] = 1;
        for (int c = fin + 1; c < MAXC; c++) e_count[c] = len;
    endtask

    task automatic reset_from(input int r);
        st_rst[r] = 1;
        for (int c = r; c < MAXC; c++) begin
            e_busy[c] = 0; e_start[c] = 0; e_done[c] = 0; e_err[c] = 0;
            e_ready[c] = 0; e_under[c] = 0; e_data[c] = 0; e_count[c] = 0;
        end
    endtask

    task automatic run(input int n);
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        for (int c = 0; c < n; c++) begin
            @(posedge clk);
            #1;
            cyc = c;
            checking = 1'b1;
            reset = 1'b0;
            frame_req = st_req[c];
            frame_len = st_len[c];
            sym_valid = st_valid[c];
            sym_data = st_data[c];
            if (st_rst[c]) #1 reset = 1'b1;
        end
        @(posedge clk);
        #1 checking = 1'b0;
        frame_req = 1'b0;
        sym_valid = 1'b0;
    endtask

    always @(negedge clk) begin
        if (checking) begin
            chk("frame_busy", cyc, int'(frame_busy), int'(e_busy[cyc]));
            chk("mod_start",  cyc, int'(mod_start),  int'(e_start[cyc]));
            chk("frame_done", cyc, int'(frame_done), int'(e_done[cyc]));
            chk("frame_err",  cyc, int'(frame_err),  int'(e_err[cyc]));
            chk("sym_ready",  cyc, int'(sym_ready),  int'(e_ready[cyc]));
            chk("underrun",   cyc, int'(underrun),   int'(e_under[cyc]));
            chk("mod_data",   cyc, int'(mod_data),   e_data[cyc]);
            chk("sym_count",  cyc, int'(sym_count),  e_count[cyc]);
            c_busy[cyc] = frame_busy; c_start[cyc] = mod_start; c_done[cyc] = frame_done;
            c_err[cyc] = frame_err; c_ready[cyc] = sym_ready; c_under[cyc] = underrun;
            c_data[cyc] = int'(mod_data); c_count[cyc] = int'(sym_count);
        end
    end

    initial begin
        int n;

        // Basic three-symbol frame.
        clear_plan();
        src = '{5, 2, 7};
        st_req[0] = 1; st_len[0] = 8'd3;
        plan_frame(0, 3);
        run(32);
        chk("lit_start1", 1, int'(c_start[1]), 1);
        chk("lit_start2", 2, int'(c_start[2]), 0);
        chk("lit_ready12", 12, int'(c_ready[12]), 1);
        chk("lit_ready16", 16, int'(c_ready[16]), 1);
        chk("lit_ready20", 20, int'(c_ready[20]), 1);
        chk("lit_ready24", 24, int'(c_ready[24]), 0);
        chk("lit_data13", 13, c_data[13], 5);
        chk("lit_data17", 17, c_data[17], 2);
        chk("lit_data24", 24, c_data[24], 7);
        chk("lit_data25", 25, c_data[25], 0);
        chk("lit_done28", 28, int'(c_done[28]), 1);
        chk("lit_busy28", 28, int'(c_busy[28]), 1);
        chk("lit_busy29", 29, int'(c_busy[29]), 0);
        chk("lit_count28", 28, c_count[28], 3);

        // Underrun in the second strobe.
        clear_plan();
        src = '{5, 2, 7};
        st_req[0] = 1; st_len[0] = 8'd3;
        st_valid[16] = 0;
        plan_frame(0, 3);
        run(32);
        chk("lit_under16", 16, int'(c_under[16]), 1);
        chk("lit_udata18", 18, c_data[18], 0);
        chk("lit_udata21", 21, c_data[21], 2);
        chk("lit_udone28", 28, int'(c_done[28]), 1);

        // Zero-length request.
        clear_plan();
        st_req[0] = 1; st_len[0] = 8'd0;
        e_err[0] = 1;
        run(6);
        chk("lit_err0", 0, int'(c_err[0]), 1);
        chk("lit_err1", 1, int'(c_err[1]), 0);
        chk("lit_zbusy1", 1, int'(c_busy[1]), 0);
        chk("lit_zstart1", 1, int'(c_start[1]), 0);

        // frame_req held through the frame, then a back-to-back one-symbol frame.
        clear_plan();
        src = '{5, 2, 7, 4};
        for (int c = 0; c <= 29; c++) begin st_req[c] = 1; st_len[c] = 8'd3; end
        st_len[29] = 8'd1;
        plan_frame(0, 3);
        plan_frame(29, 1);
        run(52);
        n = 0;
        for (int c = 2; c <= 29; c++) n += int'(c_start[c]);
        chk("lit_nostart", 29, n, 0);
        chk("lit_start30", 30, int'(c_start[30]), 1);
        chk("lit_bdata42", 42, c_data[42], 4);
        chk("lit_bdata46", 46, c_data[46], 0);
        chk("lit_done49", 49, int'(c_done[49]), 1);

        // Asynchronous reset mid-frame, then a fresh frame.
        clear_plan();
        src = '{5, 2, 7, 3, 6};
        st_req[0] = 1; st_len[0] = 8'd3;
        plan_frame(0, 3);
        reset_from(18);
        st_req[21] = 1; st_len[21] = 8'd2;
        plan_frame(21, 2);
        run(50);
        chk("lit_rbusy18", 18, int'(c_busy[18]), 0);
        chk("lit_rdata18", 18, c_data[18], 0);
        chk("lit_rcount18", 18, c_count[18], 0);
        n = 0;
        for (int c = 18; c <= 44; c++) n += int'(c_done[c]);
        chk("lit_rnodone", 44, n, 0);
        chk("lit_rstart22", 22, int'(c_start[22]), 1);
        chk("lit_rdata34", 34, c_data[34], 3);
        chk("lit_rdone45", 45, int'(c_done[45]), 1);

        // Maximum-length frame.
        clear_plan();
        for (int i = 0; i < 255; i++) src.push_back(i % 8);
        st_req[0] = 1; st_len[0] = 8'd255;
        plan_frame(0, 255);
        run(1040);
        n = 0;
        for (int c = 13; c <= 1036; c++) n += int'(c_ready[c]);
        chk("lit_strobes", 1036, n, 254);
        chk("lit_count1036", 1036, c_count[1036], 255);
        chk("lit_count1039", 1039, c_count[1039], 255);
        chk("lit_done1036", 1036, int'(c_done[1036]), 1);
        chk("lit_busy1037", 1037, int'(c_busy[1037]), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
